// File: rtl/dual_port_bram_ctrl_if.sv
// One port of the dual-port RAM: request/grant handshake, byte-enable write and
// read-data return.
interface dual_port_bram_ctrl_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  logic            req;
  logic            gnt;
  logic [DW/8-1:0] we;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   wdata;
  logic            rvalid;
  logic [DW-1:0]   rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dual_port_bram_ctrl.sv
// Single-clock true dual-port RAM with req/gnt/rvalid handshake, byte-enable
// writes, 1- or 2-cycle read latency and a hardware zero-clear engine.
module dual_port_bram_ctrl #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 clear_req,
  output logic                 init_done,
  output logic [15:0]          coll_cnt,
  dual_port_bram_ctrl_if.slave a,
  dual_port_bram_ctrl_if.slave b
);
  // state | meaning
  // CLEAR | engine writes 0 to mem[clr_addr] each cycle; no port is granted
  // RUN   | both ports granted on request
  typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   clr_addr;
  logic                    run, clr_we;
  logic                    a_wr, a_rd, b_wr, b_rd, coll;
  logic [DATA_WIDTH-1:0]   a_bm, b_bm, a_mask_w, a_data_w;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic                    a_v1, a_v2, b_v1, b_v2;
  logic [DATA_WIDTH-1:0]   a_d1, a_d2, b_d1, b_d2;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_CLEAR;
      clr_addr <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_CLEAR && !clear_req) clr_addr <= clr_addr + 1'b1;
      else                                clr_addr <= '0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_CLEAR: if (!clear_req && (&clr_addr)) state_nxt = S_RUN;
      S_RUN:   if (clear_req)                 state_nxt = S_CLEAR;
      default:                                state_nxt = S_CLEAR;
    endcase
  end

  always_comb begin
    run       = (state == S_RUN);
    clr_we    = (state == S_CLEAR);
    init_done = run;
    a.gnt     = a.req & run;
    b.gnt     = b.req & run;
    a.rvalid  = (READ_LATENCY == 2) ? a_v2 : a_v1;
    a.rdata   = (READ_LATENCY == 2) ? a_d2 : a_d1;
    b.rvalid  = (READ_LATENCY == 2) ? b_v2 : b_v1;
    b.rdata   = (READ_LATENCY == 2) ? b_d2 : b_d1;
  end

  assign a_wr = a.gnt & (|a.we);
  assign a_rd = a.gnt & ~(|a.we);
  assign b_wr = b.gnt & (|b.we);
  assign b_rd = b.gnt & ~(|b.we);
  assign coll = a_wr & b_wr & (a.addr == b.addr);

  // On a collision port A performs one merged write: its lanes win, B fills the rest.
  always_comb begin
    a_bm = '0;
    b_bm = '0;
    for (int i = 0; i < NB; i++) begin
      a_bm[i*8 +: 8] = {8{a.we[i]}};
      b_bm[i*8 +: 8] = {8{b.we[i]}};
    end
    a_mask_w = coll ? (a_bm | b_bm) : a_bm;
    a_data_w = coll ? ((a.wdata & a_bm) | (b.wdata & ~a_bm)) : a.wdata;
  end

  always_ff @(posedge clk) begin
    if (clr_we)
      mem[clr_addr] <= '0;
    if (b_wr && !coll)
      mem[b.addr] <= (mem[b.addr] & ~b_bm) | (b.wdata & b_bm);
    if (a_wr)
      mem[a.addr] <= (mem[a.addr] & ~a_mask_w) | (a_data_w & a_mask_w);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_v1 <= 1'b0; a_v2 <= 1'b0; a_d1 <= '0; a_d2 <= '0;
      b_v1 <= 1'b0; b_v2 <= 1'b0; b_d1 <= '0; b_d2 <= '0;
      coll_cnt <= '0;
    end else begin
      a_v1 <= a_rd;
      if (a_rd) a_d1 <= mem[a.addr];
      a_v2 <= a_v1;
      if (a_v1) a_d2 <= a_d1;
      b_v1 <= b_rd;
      if (b_rd) b_d1 <= mem[b.addr];
      b_v2 <= b_v1;
      if (b_v1) b_d2 <= b_d1;
      if (coll && coll_cnt != 16'hFFFF) coll_cnt <= coll_cnt + 16'd1;
    end
  end
endmodule
